data_mem_lsu: RTL



---
 rtl/lsu_pkg.sv | 62 ++++++
 rtl/dmem_bank.sv | 35 +++
 rtl/data_mem_lsu.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data memory load/store unit: size encodings,
// controller state type, and the lane/extension helpers used by data_mem_lsu.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Byte-lane write enables for an access of the given size at byte offset off.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate LSB-aligned store data so every enabled lane sees its bytes.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_B:    d = {4{wdata[7:0]}};
            SZ_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Pick the addressed lane(s) out of a word and sign- or zero-extend them.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_H:    r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_W:    r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Four-lane byte-write-enable RAM with one write port and one registered
// synchronous read port. No reset on the array so it maps onto block RAM.
module dmem_bank #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes: only enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read; rdata holds its value while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with a load/store front end. After reset the
// array is zeroed one word per cycle; then requests are taken one at a time.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds valid and its payload stable until that edge, and a
// response stays stable in RESP until rsp_valid && rsp_ready.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    lsu_state_e       state;
    lsu_state_e       next_state;
    logic [1:0]       cnt;
    logic [IDX_W-1:0] clr_idx;

    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_size;
    logic [1:0]       r_off;
    logic             r_uns;
    logic             r_we;
    logic             r_err;

    logic              accept;
    logic              req_err;
    logic              range_err;
    logic [ADDR_W-1:0] word_full;
    logic [IDX_W-1:0]  req_idx;

    logic             wr_en;
    logic [3:0]       wr_be;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_data;

    assign accept  = (state == IDLE) && req_valid;
    assign req_idx = req_addr[IDX_W+1:2];

    // Request error check: illegal size, misalignment, or word index beyond the
    // array. The index is compared at full width so high addresses never alias.
    always_comb begin
        word_full = {2'b00, req_addr[ADDR_W-1:2]};
        range_err = (word_full >= ADDR_W'(DEPTH_WORDS));
        req_err   = range_err
                  || (req_size == 2'b11)
                  || ((req_size == SZ_H) && req_addr[0])
                  || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. WAIT leaves on the edge where cnt steps down to zero,
    // so acceptance to rsp_valid is exactly READ_LATENCY edges.
    always_comb begin
        next_state = state;
        case (state)
            CLEAR: if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) next_state = IDLE;
            IDLE:  if (req_valid) next_state = (READ_LATENCY == 1) ? RESP : WAIT;
            WAIT:  if (cnt <= 2'd1) next_state = RESP;
            RESP:  if (rsp_ready) next_state = IDLE;
            default: next_state = CLEAR;
        endcase
    end

    // Output logic; response fields derive from registered request state, so
    // they stay stable for the whole RESP stall.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_err   = (state == RESP) && r_err;
        rsp_rdata = 32'h0000_0000;
        if ((state == RESP) && !r_we && !r_err) begin
            rsp_rdata = load_ext(rd_data, r_size, r_off, r_uns);
        end
    end

    // Clear sweep index and init flag; both restart on every reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_idx   <= '0;
            init_done <= 1'b0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + IDX_W'(1);
            if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                init_done <= 1'b1;
            end
        end
    end

    // Latency counter: loaded on acceptance, counts down in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
        end else if (accept) begin
            cnt <= 2'(READ_LATENCY - 1);
        end else if (state == WAIT) begin
            cnt <= cnt - 2'd1;
        end
    end

    // Capture the accepted request fields for the load path and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_size <= 2'b00;
            r_off  <= 2'b00;
            r_uns  <= 1'b0;
            r_we   <= 1'b0;
            r_err  <= 1'b0;
        end else if (accept) begin
            r_idx  <= req_idx;
            r_size <= req_size;
            r_off  <= req_addr[1:0];
            r_uns  <= req_unsigned;
            r_we   <= req_we;
            r_err  <= req_err;
        end
    end

    // Write port: zero sweep during CLEAR, otherwise a non-errored store at acceptance.
    always_comb begin
        wr_en   = 1'b0;
        wr_be   = 4'b0000;
        wr_idx  = clr_idx;
        wr_data = 32'h0000_0000;
        if (state == CLEAR) begin
            wr_en = 1'b1;
            wr_be = 4'b1111;
        end else if (accept && req_we && !req_err) begin
            wr_en   = 1'b1;
            wr_be   = byte_en(req_size, req_addr[1:0]);
            wr_idx  = req_idx;
            wr_data = store_lanes(req_size, req_wdata);
        end
    end

    // Read port fires on the edge entering RESP; with single-cycle latency that
    // is the acceptance edge, so the live request index is used then.
    always_comb begin
        rd_en  = (state != RESP) && (state != CLEAR) && (next_state == RESP);
        rd_idx = (state == IDLE) ? req_idx : r_idx;
    end

    dmem_bank #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk   (clk),
        .we    (wr_en),
        .be    (wr_be),
        .waddr (wr_idx),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

endmodule
